// File: rtl/sram_emu_pipelined.sv
// Pipelined emulated mixed-signal SRAM with valid/ready requests and power-on clear.
// Optional parity storage enabled by defining SRAM_EMU_PARITY_EN.
`timescale 1ns/1ps
module sram_emu_pipelined #(
  parameter int DATA_WIDTH  = 8,
  parameter int ADDR_WIDTH  = 4,
  parameter int ANA_WIDTH   = 8,
  parameter int FULL_SCALE  = 255,
  parameter int THRESHOLD   = 128,
  parameter int RD_LATENCY  = 2,
  parameter int WRITE_FIRST = 0
) (
  input  logic                                 clk,
  input  logic                                 rst_n,
  input  logic                                 req_valid,
  output logic                                 req_ready,
  input  logic                                 req_we,
  input  logic [ADDR_WIDTH-1:0][ANA_WIDTH-1:0] addr_a,
  input  logic [DATA_WIDTH-1:0][ANA_WIDTH-1:0] din_a,
  input  logic                                 err_inj,
  output logic                                 rsp_valid,
  output logic [DATA_WIDTH-1:0][ANA_WIDTH-1:0] dout_a,
  output logic                                 par_err,
  output logic                                 init_done
);

  localparam int DEPTH = 2**ADDR_WIDTH;
  localparam logic [ANA_WIDTH-1:0] VTH = ANA_WIDTH'(THRESHOLD);
  localparam logic [ANA_WIDTH-1:0] VDD = ANA_WIDTH'(FULL_SCALE);

  typedef enum logic {S_INIT, S_RUN} state_e;

  state_e                 state_q, state_d;
  logic [ADDR_WIDTH-1:0]  cnt_q, cnt_d;

  logic [ADDR_WIDTH-1:0]  addr_bin;
  logic [DATA_WIDTH-1:0]  din_bin;
  logic                   acc;
  logic                   wr_new;

  logic [DATA_WIDTH-1:0]  mem_q [DEPTH];
  logic                   mem_we;
  logic [ADDR_WIDTH-1:0]  mem_wa;
  logic [DATA_WIDTH-1:0]  mem_wd;
  logic [DATA_WIDTH-1:0]  rsp_word;

  logic [RD_LATENCY-1:0]                 vld_q;
  logic [RD_LATENCY-1:0][DATA_WIDTH-1:0] dat_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= S_INIT;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
    end
  end

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    if (state_q == S_INIT) begin
      cnt_d = cnt_q + 1'b1;
      if (&cnt_q) state_d = S_RUN;
    end
  end

  assign req_ready = (state_q == S_RUN);
  assign init_done = (state_q == S_RUN);
  assign acc       = req_valid & req_ready;

  // Emulated comparator: a line at exactly VTH still reads as 0.
  always_comb begin
    addr_bin = '0;
    din_bin  = '0;
    for (int i = 0; i < ADDR_WIDTH; i++)
      addr_bin[i] = addr_a[i] > VTH;
    for (int i = 0; i < DATA_WIDTH; i++)
      din_bin[i] = din_a[i] > VTH;
  end

  always_comb begin
    mem_we = 1'b0;
    mem_wa = addr_bin;
    mem_wd = din_bin;
    if (state_q == S_INIT) begin
      mem_we = 1'b1;
      mem_wa = cnt_q;
      mem_wd = '0;
    end else if (acc && req_we) begin
      mem_we = 1'b1;
    end
  end

  assign wr_new   = req_we && (WRITE_FIRST != 0);
  assign rsp_word = wr_new ? din_bin : mem_q[addr_bin];

  always_ff @(posedge clk) begin
    if (mem_we) mem_q[mem_wa] <= mem_wd;
  end

  // Stages load only behind a valid, so the last stage holds between responses.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      vld_q <= '0;
      dat_q <= '0;
    end else begin
      vld_q[0] <= acc;
      if (acc) dat_q[0] <= rsp_word;
      for (int i = 1; i < RD_LATENCY; i++) begin
        vld_q[i] <= vld_q[i-1];
        if (vld_q[i-1]) dat_q[i] <= dat_q[i-1];
      end
    end
  end

  assign rsp_valid = vld_q[RD_LATENCY-1];

  always_comb begin
    dout_a = '0;
    for (int i = 0; i < DATA_WIDTH; i++)
      dout_a[i] = dat_q[RD_LATENCY-1][i] ? VDD : '0;
  end

`ifdef SRAM_EMU_PARITY_EN
  logic                  par_mem_q [DEPTH];
  logic                  par_wd;
  logic                  rsp_par;
  logic [RD_LATENCY-1:0] par_q;

  assign par_wd  = (state_q == S_INIT) ? 1'b0 : ((^din_bin) ^ err_inj);
  assign rsp_par = wr_new ? par_wd : par_mem_q[addr_bin];

  always_ff @(posedge clk) begin
    if (mem_we) par_mem_q[mem_wa] <= par_wd;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      par_q <= '0;
    end else begin
      if (acc) par_q[0] <= rsp_par;
      for (int i = 1; i < RD_LATENCY; i++)
        if (vld_q[i-1]) par_q[i] <= par_q[i-1];
    end
  end

  assign par_err = rsp_valid &
                   ((^dat_q[RD_LATENCY-1]) ^ par_q[RD_LATENCY-1]);
`else
  logic unused_err_inj;
  assign unused_err_inj = err_inj;
  assign par_err        = 1'b0;
`endif

endmodule
